// File: rtl/addsub_serial.sv
// Chunk-serial adder/subtractor: cw bits per cycle, LSB first, with carry/overflow/zero flags.
// Optional result saturation on signed overflow when the ADDSUB_SAT_EN macro is defined.
module addsub_serial #(
  parameter int dw = 8,
  parameter int cw = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [dw-1:0] dataa,
  input  logic [dw-1:0] datab,
  input  logic          add_sub,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] result,
  output logic          carry,
  output logic          overflow,
  output logic          zero
);

  localparam int NCH  = dw / cw;
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [dw-1:0]   opa_q, opa_d;
  logic [dw-1:0]   opb_q, opb_d;
  logic [dw-1:0]   sum_q, sum_d;
  logic            c_q, c_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [dw-1:0]   res_q, res_d;
  logic            cy_q, cy_d;
  logic            ov_q, ov_d;
  logic            z_q, z_d;

  logic [cw:0]     chunk_sum;
  logic [dw-1:0]   sum_full;
  logic [dw-1:0]   res_fin;
  logic            a_msb, b_msb, s_msb, cin_msb, cout, ovf;

  // Operands shift right each RUN cycle, so the current chunk is always in the low cw bits.
  assign chunk_sum = {1'b0, opa_q[cw-1:0]} + {1'b0, opb_q[cw-1:0]} + {{cw{1'b0}}, c_q};
  assign sum_full  = dw'({chunk_sum[cw-1:0], sum_q} >> cw);

  // On the last chunk these bits are the operand/sum MSBs; carry into the MSB is recovered from them.
  assign a_msb   = opa_q[cw-1];
  assign b_msb   = opb_q[cw-1];
  assign s_msb   = sum_full[dw-1];
  assign cin_msb = a_msb ^ b_msb ^ s_msb;
  assign cout    = chunk_sum[cw];
  assign ovf     = cin_msb ^ cout;

`ifdef ADDSUB_SAT_EN
  // Overflow only happens with equal operand signs, so a_msb gives the sign of the true sum.
  assign res_fin = ovf ? (a_msb ? {1'b1, {(dw-1){1'b0}}} : {1'b0, {(dw-1){1'b1}}}) : sum_full;
`else
  assign res_fin = sum_full;
`endif

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = dataa;
          opb_d   = add_sub ? datab : ~datab;
          c_d     = ~add_sub;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d = opa_q >> cw;
        opb_d = opb_q >> cw;
        sum_d = sum_full;
        c_d   = cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = res_fin;
          cy_d    = cout;
          ov_d    = ovf;
          z_d     = (res_fin == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign carry    = cy_q;
  assign overflow = ov_q;
  assign zero     = z_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (dw=8, cw=2): directed vector table, hand-written corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_addsub_serial;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int NCH = DW / CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          add_sub;
  logic [DW-1:0] dataa, datab;
  logic          busy, done, carry, overflow, zero;
  logic [DW-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_serial #(.dw(DW), .cw(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataa(dataa), .datab(datab),
    .add_sub(add_sub), .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       as;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic as);
    int ua, ub, sa, sb, tr;
    logic [7:0] r;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (as) begin
      tr = sa + sb;
      c  = (ua + ub) > 255;
      r  = 8'((ua + ub) % 256);
    end else begin
      tr = sa - sb;
      c  = (ua >= ub);
      r  = 8'((ua - ub + 256) % 256);
    end
    v = (tr > 127) || (tr < -128);
`ifdef ADDSUB_SAT_EN
    if (tr > 127)  r = 8'h7F;
    if (tr < -128) r = 8'h80;
`endif
    return {r, c, v, (r == 8'h00)};
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic as,
                        input logic [7:0] er, input logic ec, input logic ev, input logic ez,
                        input string nm);
    int k;
    @(negedge clk);
    dataa = a; datab = b; add_sub = as; start = 1'b1;
    @(posedge clk); #1;
    chk({nm, ".busy0"}, busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    dataa = 8'($urandom); datab = 8'($urandom); add_sub = 1'($urandom);
    k = 0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    chk({nm, ".lat"}, k, NCH);
    chk({nm, ".res"}, result, er);
    chk({nm, ".carry"}, carry, ec);
    chk({nm, ".ovf"}, overflow, ev);
    chk({nm, ".zero"}, zero, ez);
    @(posedge clk); #1;
    chk({nm, ".done_end"}, {busy, done}, 2'b00);
    chk({nm, ".hold"}, result, er);
  endtask

  vec_t tbl[6];

  initial begin
    int dcount;
    logic [10:0] m;
    logic [7:0] ra, rb;
    logic ras;

    tbl[0] = '{8'h3C, 8'h05, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    tbl[4] = '{8'h7F, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    tbl[4] = '{8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif

    rst_n = 1'b1; start = 1'b0; add_sub = 1'b0; dataa = '0; datab = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset.outs", {busy, done, result, carry, overflow, zero}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z,
             $sformatf("vec%0d", i));

    // Reset during the second RUN cycle: outputs clear at once and no done appears.
    @(negedge clk);
    dataa = 8'h40; datab = 8'h22; add_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.busy", busy, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst_mid.outs", {busy, done, result, carry, overflow, zero}, '0);
    @(negedge clk) rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("rst_mid.nodone", dcount, 0);
    run_op(8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "rst_after");

    // Start pulses and operand changes while busy must be ignored.
    @(negedge clk);
    dataa = 8'h10; datab = 8'h20; add_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b1; dataa = 8'hAA; datab = 8'h55; add_sub = i[0];
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        chk("busy_start.lat", i, NCH);
        chk("busy_start.res", result, 8'h30);
      end
    end
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("busy_start.ndone", dcount, 1);
    chk("busy_start.idle", busy, 1'b0);
    chk("busy_start.hold", result, 8'h30);
    run_op(8'hAA, 8'h55, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "idle_start");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); ras = 1'($urandom);
      if (i < 4) begin ra = 8'h80 | ra; rb = 8'h80 | rb; end
      m = model(ra, rb, ras);
      run_op(ra, rb, ras, m[10:3], m[2], m[1], m[0], $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter dw, default 8: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter cw, default 2: chunk width processed per cycle; SHALL satisfy 1 <= cw <= dw and dw % cw == 0; NCH = dw/cw.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 start  input  1: request a new operation; sampled only in IDLE.
REQ-006 dataa  input  dw: first operand, sampled with start.
REQ-007 datab  input  dw: second operand, sampled with start.
REQ-008 add_sub  input  1: 1 = dataa + datab, 0 = dataa - datab; sampled with start.
REQ-009 busy  output  1: high in RUN and DONE.
REQ-010 done  output  1: one-cycle pulse; result and flags valid and final.
REQ-011 result  output  dw: registered result, held from done until the next completion.
REQ-012 carry  output  1: carry out of MSB (subtract: 1 = no borrow, i.e. dataa >= datab unsigned).
REQ-013 overflow  output  1: two's-complement signed overflow of the operation.
REQ-014 zero  output  1: result == 0 (after saturation when enabled).

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; power-up/reset state IDLE.
REQ-016 IDLE with start=1 at an edge: latch dataa, latch datab (inverted if add_sub=0), set carry-in to ~add_sub, set the chunk counter to 0, and go to RUN.
REQ-017 In RUN, each edge SHALL add chunk[counter] (cw bits, LSB-first) of both latched operands plus the running carry, store the cw sum bits, and increment the counter.
REQ-018 RUN SHALL go to DONE at the edge processing chunk NCH-1; DONE SHALL go to IDLE unconditionally at the next edge.
REQ-019 result, carry, overflow, and zero SHALL be updated only on entry to DONE; done=1 exactly during DONE.
REQ-020 Latency: done SHALL be high in the cycle following the NCH-th edge after the start-sampling edge; the minimum start-to-start spacing is NCH+2 cycles.
REQ-021 start while busy=1 SHALL be ignored with no effect on the operation in progress; operand changes after sampling SHALL have no effect.
REQ-022 overflow = carry into MSB XOR carry out of MSB; carry = final carry out, including for subtraction.
REQ-023 With cw == dw, the whole operation SHALL complete in one RUN cycle (NCH=1).

Reset
REQ-024 rst_n low SHALL immediately force IDLE; busy, done, result, carry, overflow, and zero SHALL be 0; internal operands and counter SHALL be cleared.
REQ-025 Reset during RUN or DONE SHALL abandon the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro ADDSUB_SAT_EN defined: on overflow=1, result SHALL clamp to 2^(dw-1)-1 if the true sum is positive or -2^(dw-1) if negative; overflow still reports 1.
REQ-027 Macro ADDSUB_SAT_EN undefined: result SHALL wrap modulo 2^dw; no saturation logic is present.

Verification (dw=8, cw=2, NCH=4)
REQ-028 start, 0x3C + 0x05, add_sub=1 -> done on the 5th cycle after start, result=0x41, carry=0, overflow=0, zero=0; then 0xFF + 0x01 -> result=0x00, carry=1, zero=1, overflow=0.
REQ-029 0x05 - 0x05, add_sub=0 -> result=0x00, zero=1, carry=1, overflow=0; 0x03 - 0x05 -> result=0xFE, carry=0, overflow=0.
REQ-030 0x7F + 0x01 -> overflow=1, carry=0; result=0x80 without ADDSUB_SAT_EN, 0x7F with it; 0x80 - 0x01 -> overflow=1, carry=1; result=0x7F without, 0x80 with.
REQ-031 start with 0x10 + 0x20, then start pulses with 0xAA/0x55 during RUN and DONE -> single done, result=0x30; the next start is accepted only from IDLE.
REQ-032 rst_n low for 1 cycle during the 2nd RUN cycle -> all outputs 0 at once, no done; a following start with 0x01 + 0x01 -> result=0x02 after the normal latency.
